mac_feeder: RTL and testbench
=============================

# mac_feeder

Sequencing stage directly upstream of the `mac` accumulator in the CNN datapath. It holds one kernel's weights in a small local bank and accepts a pixel stream over a valid/ready handshake. For each window it pairs every pixel with its weight tap and drives the MAC's `pixel`, `weight`, `reg_en` and `clr` inputs. After the last tap it captures the 12-bit accumulated result and presents it downstream on a valid/ready handshake.

## Interface
- `KERNEL_SIZE`, 3: kernel edge; taps per window `N = KERNEL_SIZE*KERNEL_SIZE`.
- `DATA_W`, 8: pixel and weight width; matches MAC inputs.
- `RES_W`, 12: MAC result width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wt_we` in 1: weight write strobe; honoured only in IDLE.
- `wt_addr` in `$clog2(N)`: tap index to write; values ≥ N are ignored.
- `wt_data` in `DATA_W`: weight value.
- `in_valid` in 1: pixel available.
- `in_pixel` in `DATA_W`: pixel, taps in raster order.
- `in_ready` out 1: feeder accepts the pixel this cycle.
- `mac_pixel` out `DATA_W`: to MAC `pixel`.
- `mac_weight` out `DATA_W`: to MAC `weight`.
- `mac_reg_en` out 1: to MAC `reg_en`.
- `mac_clr` out 1: to MAC `clr`.
- `mac_result` in `RES_W`: from MAC `result`.
- `out_valid` out 1: window result available.
- `out_data` out `RES_W`: window result.
- `out_ready` in 1: downstream accepts the result.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: `in_ready=0`; weight writes are accepted. `in_valid=1` → CLEAR.
  - CLEAR: one cycle; `mac_clr=1`, `mac_reg_en=0`, tap counter reset to 0. Always → ACCUM.
  - ACCUM: `in_ready=1`. On accept (`in_valid & in_ready`), `mac_reg_en=1`, `mac_pixel=in_pixel` (combinational pass-through) and `mac_weight=weight[tap]`, then tap increments. Without an accept, `mac_reg_en=0` and tap holds. Accepting tap N-1 → CAPTURE.
  - CAPTURE: one cycle; `mac_result` is final. `out_data <= mac_result`. → OUT.
  - OUT: `out_valid=1`, `in_ready=0`. On `out_ready`, go to CLEAR if `in_valid=1`, else IDLE.
- `mac_clr` and `mac_reg_en` are never high together.
- Arithmetic belongs to the MAC and wraps modulo 2^RES_W. The feeder does no saturation.
- Weight writes (`wt_we`) in any state other than IDLE are dropped and the bank is unchanged.
- Weights persist across windows. Only `rst` clears the bank.

## Timing
- Reset values: state IDLE, tap 0, weight bank all 0, `out_data=0`. `out_valid`, `in_ready`, `mac_reg_en`, `mac_clr` and `busy` are all 0. `mac_pixel=0` and `mac_weight=0` whenever `mac_reg_en=0`.
- Latency with back-to-back input: `in_valid` rises in IDLE at cycle 0. CLEAR is cycle 1, taps are accepted in cycles 2..N+1, CAPTURE is cycle N+2, and `out_valid` is high from cycle N+3.
- Window-to-window throughput: N+3 cycles minimum (CLEAR, N taps, CAPTURE, OUT).
- `out_data` and `out_valid` stay stable while `out_ready=0`. No input is accepted during OUT.
- `in_valid` gaps in ACCUM stall the tap counter and the MAC. A partial window never completes early.
- Asserting `rst` mid-window returns the block to IDLE immediately. It also clears the weights, deasserts every output and discards the partial window. The MAC's register is cleared on the next CLEAR.

## Structure
- Package `mac_feeder_pkg`: state enum `feeder_state_t` {IDLE, CLEAR, ACCUM, CAPTURE, OUT} and default width constants.
- Sub-module `weight_bank`: N×DATA_W register file with one synchronous write port (`we`, `addr`, `data`) and one combinational read port indexed by tap. It has the same asynchronous active-low `rst`.
- The FSM, tap counter and result register live in `mac_feeder`.
- The bench instantiates `mac_feeder` wired to the existing `mac`.

## Test plan
- Load weights 1 on all 9 taps, then stream pixels 1..9 back-to-back → one result 45, with `out_valid` first seen 12 cycles after `in_valid` rose.
- Load weights 0..8, stream nine pixels of 1 → 36. Start a second window at once with pixels of 2 → 72; the MAC is cleared between windows, so there is no carry-over of 36.
- Stream pixels with `in_valid` low on alternate cycles → same result as the back-to-back case; `mac_reg_en` pulses exactly 9 times per window.
- Hold `out_ready=0` for 5 cycles in OUT → `out_data` is stable, `in_ready=0`, no MAC activity. The result is accepted on the cycle `out_ready` rises.
- Pulse `wt_we` with addr 0, data 7 during ACCUM → ignored, result unchanged. The same write in IDLE → the next window uses weight 7 on tap 0.
- Assert `rst` after 4 taps → all outputs are 0, state is IDLE, weights read back 0. A following full window of pixels 1 (after reloading weights 1) → 9.

Source files
------------

// File: rtl/mac_feeder_pkg.sv
// ---------------------------------------------------------------------------
// mac_feeder_pkg
//
// Shared definitions for the MAC feeder slice: the feeder state encoding,
// default geometry/width constants and a small helper that sizes the tap
// index so a 1x1 kernel still gets a 1-bit counter.
// ---------------------------------------------------------------------------
package mac_feeder_pkg;

   // Default kernel edge; taps per window is the square of this.
   localparam int DEF_KERNEL_SIZE = 3;

   // Pixel and weight width, matching the MAC operand inputs.
   localparam int DEF_DATA_W = 8;

   // Width of the MAC accumulated result.
   localparam int DEF_RES_W = 12;

   // Default number of taps per window.
   localparam int DEF_N = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;

   // Window sequencing states.
   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      CAPTURE,
      OUT
   } feeder_state_t;

   // Width of a tap index for n taps, never less than one bit.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// ---------------------------------------------------------------------------
// mac_feeder_if
//
// Bundles every non-clock signal of the feeder: the weight write port, the
// pixel valid/ready stream, the MAC drive/return signals, the result
// valid/ready stream and the busy flag.
//
// Signals:
//    wt_we, wt_addr, wt_data   weight write strobe, tap index, weight value
//    in_valid, in_pixel        upstream pixel stream
//    in_ready                  feeder accepts the pixel this cycle
//    mac_pixel, mac_weight     operands to the MAC
//    mac_reg_en, mac_clr       MAC accumulate enable / clear
//    mac_result                accumulated value from the MAC
//    out_valid, out_data       window result towards downstream
//    out_ready                 downstream accepts the result
//    busy                      feeder is not idle
//
// Modports:
//    slave   the feeder itself
//    master  whoever drives the feeder (upstream, MAC, downstream together)
// ---------------------------------------------------------------------------
interface mac_feeder_if #(
   parameter int DATA_W = mac_feeder_pkg::DEF_DATA_W,
   parameter int RES_W  = mac_feeder_pkg::DEF_RES_W,
   parameter int N      = mac_feeder_pkg::DEF_N
);
   import mac_feeder_pkg::*;

   localparam int ADDR_W = addr_width(N);

   logic              wt_we;
   logic [ADDR_W-1:0] wt_addr;
   logic [DATA_W-1:0] wt_data;

   logic              in_valid;
   logic [DATA_W-1:0] in_pixel;
   logic              in_ready;

   logic [DATA_W-1:0] mac_pixel;
   logic [DATA_W-1:0] mac_weight;
   logic              mac_reg_en;
   logic              mac_clr;
   logic [RES_W-1:0]  mac_result;

   logic              out_valid;
   logic [RES_W-1:0]  out_data;
   logic              out_ready;

   logic              busy;

   modport slave (
      input  wt_we, wt_addr, wt_data,
      input  in_valid, in_pixel,
      output in_ready,
      output mac_pixel, mac_weight, mac_reg_en, mac_clr,
      input  mac_result,
      output out_valid, out_data,
      input  out_ready,
      output busy
   );

   modport master (
      output wt_we, wt_addr, wt_data,
      output in_valid, in_pixel,
      input  in_ready,
      input  mac_pixel, mac_weight, mac_reg_en, mac_clr,
      output mac_result,
      input  out_valid, out_data,
      output out_ready,
      input  busy
   );

endinterface

// File: rtl/mac_feeder_weight_bank.sv
// ---------------------------------------------------------------------------
// weight_bank
//
// N x DATA_W register file holding one kernel's weights.
//
// Ports:
//    clk      rising-edge clock
//    rst      asynchronous active-low reset, clears every weight
//    we       write strobe (already qualified by the caller's state)
//    addr     write tap index; indices past the last tap are dropped
//    data     write value
//    rd_addr  read tap index
//    rd_data  combinational read of the addressed weight
// ---------------------------------------------------------------------------
module weight_bank
   import mac_feeder_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = addr_width(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N - 1);

   logic [DATA_W-1:0] mem_q [N];

   // Storage: cleared only by reset; a write to an index beyond the last
   // tap would otherwise fall outside the array, so it is simply dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we && (addr <= LAST_TAP)) begin
         mem_q[addr] <= data;
      end
   end

   // Read port: the tap counter never leaves range, but the guard keeps the
   // read well defined for non-power-of-two tap counts.
   always_comb begin
      rd_data = '0;
      if (rd_addr <= LAST_TAP) begin
         rd_data = mem_q[rd_addr];
      end
   end

endmodule

// File: rtl/mac_feeder.sv
// ---------------------------------------------------------------------------
// mac_feeder
//
// Sequencing stage in front of the MAC accumulator. Holds one kernel's
// weights, pairs each accepted pixel with its weight tap, drives the MAC
// clear/enable, and captures the final accumulated result for downstream.
//
// Ports:
//    clk   rising-edge clock
//    rst   asynchronous active-low reset
//    bus   mac_feeder_if.slave carrying the weight write port, pixel stream,
//          MAC drive/return, result stream and busy flag
//
// Window flow: IDLE -> CLEAR (MAC cleared) -> ACCUM (N accepted taps)
// -> CAPTURE (result latched) -> OUT (held until out_ready).
// ---------------------------------------------------------------------------
module mac_feeder
   import mac_feeder_pkg::*;
#(
   parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int RES_W       = DEF_RES_W
) (
   input logic        clk,
   input logic        rst,
   mac_feeder_if.slave bus
);

   localparam int N      = KERNEL_SIZE * KERNEL_SIZE;
   localparam int ADDR_W = addr_width(N);

   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N - 1);
   localparam logic [ADDR_W-1:0] TAP_ONE  = ADDR_W'(1);

   feeder_state_t     state_q, state_d;
   logic [ADDR_W-1:0] tap_q, tap_d;
   logic [RES_W-1:0]  out_data_q, out_data_d;

   logic              in_ready;
   logic              accept;
   logic              mac_reg_en;
   logic              mac_clr;
   logic [DATA_W-1:0] mac_pixel;
   logic [DATA_W-1:0] mac_weight;
   logic              out_valid;
   logic              bank_we;
   logic [DATA_W-1:0] tap_weight;

   // Weight writes only land while idle so a running window always sees a
   // consistent kernel.
   assign bank_we = bus.wt_we && (state_q == IDLE);

   weight_bank #(
      .N      (N),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (bank_we),
      .addr    (bus.wt_addr),
      .data    (bus.wt_data),
      .rd_addr (tap_q),
      .rd_data (tap_weight)
   );

   assign accept = bus.in_valid && in_ready;

   // State register: FSM state, tap counter and captured result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         tap_q      <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         tap_q      <= tap_d;
         out_data_q <= out_data_d;
      end
   end

   // Next-state logic: the tap counter only moves on an accepted pixel, so
   // input gaps stall the window; leaving OUT goes straight to CLEAR when
   // another pixel is already waiting.
   always_comb begin
      state_d    = state_q;
      tap_d      = tap_q;
      out_data_d = out_data_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            tap_d   = '0;
            state_d = ACCUM;
         end
         ACCUM: begin
            if (accept) begin
               if (tap_q == LAST_TAP) begin
                  tap_d   = '0;
                  state_d = CAPTURE;
               end else begin
                  tap_d = tap_q + TAP_ONE;
               end
            end
         end
         CAPTURE: begin
            out_data_d = bus.mac_result;
            state_d    = OUT;
         end
         OUT: begin
            if (bus.out_ready) begin
               state_d = bus.in_valid ? CLEAR : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode: MAC operands are forced to zero unless a tap is being
   // accumulated this cycle, and clear/enable come from disjoint states so
   // they can never overlap.
   always_comb begin
      in_ready   = 1'b0;
      mac_reg_en = 1'b0;
      mac_clr    = 1'b0;
      mac_pixel  = '0;
      mac_weight = '0;
      out_valid  = 1'b0;
      case (state_q)
         CLEAR: begin
            mac_clr = 1'b1;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               mac_reg_en = 1'b1;
               mac_pixel  = bus.in_pixel;
               mac_weight = tap_weight;
            end
         end
         OUT: begin
            out_valid = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.in_ready   = in_ready;
   assign bus.mac_pixel  = mac_pixel;
   assign bus.mac_weight = mac_weight;
   assign bus.mac_reg_en = mac_reg_en;
   assign bus.mac_clr    = mac_clr;
   assign bus.out_valid  = out_valid;
   assign bus.out_data   = out_data_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mac_feeder.sv
// ---------------------------------------------------------------------------
// tb_mac_feeder
//
// Directed bench for mac_feeder driving a small behavioural MAC model.
// ---------------------------------------------------------------------------
module tb_mac_feeder;

   localparam int N = 9;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int total = 0;
   int bad   = 0;

   logic [7:0] winPix [N];

   always #5 clk = ~clk;

   mac_feeder_if #(.DATA_W(8), .RES_W(12), .N(N)) bus ();

   mac_feeder #(
      .KERNEL_SIZE (3),
      .DATA_W      (8),
      .RES_W       (12)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Stand-in for the downstream MAC: clear wins, otherwise accumulate
   // pixel*weight modulo 2^12 when enabled.
   logic [11:0] macAcc = '0;
   logic [15:0] macProd;
   assign macProd        = 16'(bus.mac_pixel) * 16'(bus.mac_weight);
   assign bus.mac_result = macAcc;

   always @(posedge clk) begin
      if (bus.mac_clr) begin
         macAcc <= '0;
      end else if (bus.mac_reg_en) begin
         macAcc <= macAcc + macProd[11:0];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [7:0] pixel,
                                input logic outReady);
      bus.in_valid  = valid;
      bus.in_pixel  = pixel;
      bus.out_ready = outReady;
   endtask

   task automatic writeWeight(input logic [3:0] addr, input logic [7:0] data);
      bus.wt_addr = addr;
      bus.wt_data = data;
      bus.wt_we   = 1'b1;
      @(posedge clk); #1;
      bus.wt_we   = 1'b0;
   endtask

   task automatic fillPixels(input logic [7:0] value);
      for (int i = 0; i < N; i++) winPix[i] = value;
   endtask

   // Streams winPix until out_valid appears; optionally leaves a gap on odd
   // cycles and pulses a weight write (tap 0 <= 7) on cycle injectAt.
   task automatic streamWindow(input bit gaps, input int injectAt,
                               output int cycles, output int pulses);
      int idx;
      bit acc;
      idx    = 0;
      cycles = 0;
      pulses = 0;
      while (bus.out_valid !== 1'b1 && cycles < 200) begin
         if (idx < N && (!gaps || (cycles % 2) == 0))
            applyStimulus(1'b1, winPix[idx], 1'b0);
         else
            applyStimulus(1'b0, 8'd0, 1'b0);
         bus.wt_addr = 4'd0;
         bus.wt_data = 8'd7;
         bus.wt_we   = (cycles == injectAt);
         #1;
         if (bus.mac_reg_en === 1'b1) pulses++;
         checkOutput("clr_and_en", 32'(bus.mac_clr & bus.mac_reg_en), 0);
         if (bus.mac_reg_en !== 1'b1)
            checkOutput("gated_operands", {bus.mac_pixel, bus.mac_weight}, 0);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         cycles++;
         if (acc) idx++;
      end
      bus.wt_we = 1'b0;
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkOutput("window_done", 32'(bus.out_valid), 1);
   endtask

   task automatic acceptResult(input logic nextValid, input logic [7:0] nextPix);
      applyStimulus(nextValid, nextPix, 1'b1);
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkOutput("released", 32'(bus.out_valid), 0);
   endtask

   initial begin
      int cyc;
      int pul;

      applyStimulus(1'b0, 8'd0, 1'b0);
      bus.wt_we   = 1'b0;
      bus.wt_addr = 4'd0;
      bus.wt_data = 8'd0;

      // Reset state
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
      checkOutput("rst_reg_en", 32'(bus.mac_reg_en), 0);
      checkOutput("rst_clr", 32'(bus.mac_clr), 0);
      checkOutput("rst_busy", 32'(bus.busy), 0);
      checkOutput("rst_out_data", 32'(bus.out_data), 0);
      #2 rst = 1'b1;
      @(posedge clk); #1;

      // Weights 1, pixels 1..9 back-to-back: 45 with 12-cycle latency
      $display("[TB] back-to-back window");
      for (int i = 0; i < N; i++) begin
         writeWeight(4'(i), 8'd1);
         winPix[i] = 8'(i + 1);
      end
      streamWindow(1'b0, -1, cyc, pul);
      checkOutput("b2b_latency", cyc, 12);
      checkOutput("b2b_pulses", pul, 9);
      checkOutput("b2b_result", 32'(bus.out_data), 45);
      acceptResult(1'b0, 8'd0);
      checkOutput("b2b_idle", 32'(bus.busy), 0);

      // Same window with alternate-cycle gaps
      $display("[TB] gapped window");
      streamWindow(1'b1, -1, cyc, pul);
      checkOutput("gap_cycles", cyc, 20);
      checkOutput("gap_pulses", pul, 9);
      checkOutput("gap_result", 32'(bus.out_data), 45);

      // Hold in OUT with out_ready low while a pixel is offered
      $display("[TB] output backpressure");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, 8'hAA, 1'b0);
         #1;
         checkOutput("hold_valid", 32'(bus.out_valid), 1);
         checkOutput("hold_data", 32'(bus.out_data), 45);
         checkOutput("hold_in_ready", 32'(bus.in_ready), 0);
         checkOutput("hold_mac_idle", 32'({bus.mac_reg_en, bus.mac_clr}), 0);
         @(posedge clk); #1;
      end
      checkOutput("hold_mac_result", 32'(bus.mac_result), 45);
      acceptResult(1'b0, 8'd0);
      checkOutput("hold_idle", 32'(bus.busy), 0);

      // Weights 0..8 (out-of-range writes dropped), pixels 1 then 2
      $display("[TB] consecutive windows");
      for (int i = 0; i < N; i++) writeWeight(4'(i), 8'(i));
      writeWeight(4'd9, 8'd200);
      writeWeight(4'd15, 8'd200);
      fillPixels(8'd1);
      streamWindow(1'b0, -1, cyc, pul);
      checkOutput("w1_result", 32'(bus.out_data), 36);
      fillPixels(8'd2);
      acceptResult(1'b1, 8'd2);
      checkOutput("w2_clear", 32'(bus.mac_clr), 1);
      streamWindow(1'b0, -1, cyc, pul);
      checkOutput("w2_cycles", cyc, 11);
      checkOutput("w2_result", 32'(bus.out_data), 72);
      acceptResult(1'b0, 8'd0);

      // Weight write during ACCUM is dropped, in IDLE it sticks
      $display("[TB] weight write gating");
      fillPixels(8'd1);
      streamWindow(1'b0, 5, cyc, pul);
      checkOutput("wr_accum_result", 32'(bus.out_data), 36);
      acceptResult(1'b0, 8'd0);
      streamWindow(1'b0, -1, cyc, pul);
      checkOutput("wr_accum_after", 32'(bus.out_data), 36);
      acceptResult(1'b0, 8'd0);
      writeWeight(4'd0, 8'd7);
      streamWindow(1'b0, -1, cyc, pul);
      checkOutput("wr_idle_result", 32'(bus.out_data), 43);
      acceptResult(1'b0, 8'd0);

      // Reset after four taps
      $display("[TB] mid-window reset");
      applyStimulus(1'b1, 8'd1, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("pre_rst_busy", 32'(bus.busy), 1);
      rst = 1'b0;
      #1;
      checkOutput("mrst_out_valid", 32'(bus.out_valid), 0);
      checkOutput("mrst_in_ready", 32'(bus.in_ready), 0);
      checkOutput("mrst_reg_en", 32'(bus.mac_reg_en), 0);
      checkOutput("mrst_clr", 32'(bus.mac_clr), 0);
      checkOutput("mrst_busy", 32'(bus.busy), 0);
      checkOutput("mrst_out_data", 32'(bus.out_data), 0);
      checkOutput("mrst_operands", {bus.mac_pixel, bus.mac_weight}, 0);
      applyStimulus(1'b0, 8'd0, 1'b0);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      streamWindow(1'b0, -1, cyc, pul);
      checkOutput("mrst_zero_weights", 32'(bus.out_data), 0);
      acceptResult(1'b0, 8'd0);
      for (int i = 0; i < N; i++) writeWeight(4'(i), 8'd1);
      streamWindow(1'b0, -1, cyc, pul);
      checkOutput("mrst_reload_result", 32'(bus.out_data), 9);
      acceptResult(1'b0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
